// File: rtl/dnn_seq_pkg.sv
// Shared definitions for the DNN command sequencer: command-word field layout,
// mode encodings and the sequencer state type.
package dnn_seq_pkg;

  localparam logic [3:0] MODE_NOP     = 4'd0;
  localparam logic [3:0] MODE_COMPUTE = 4'd1;
  localparam logic [3:0] MODE_WRITE   = 4'd2;

  // Bits [PASS_MSB:0] go to the controller untouched; [31:LEN_LSB] is the burst length.
  localparam int LEN_LSB  = 24;
  localparam int PASS_MSB = 23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_WRITE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with a registered head word. A push into an empty FIFO becomes
// visible one cycle later; a push is refused while full, even alongside a pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  import dnn_seq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == FULL_COUNT);
  assign push_ok     = push & ~full;
  assign pop_ok      = pop & ~empty;
  assign rd_ptr_next = rd_ptr_reg + 1'b1;
  assign head        = head_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The head register tracks the oldest entry; the write port only feeds
      // it directly when the incoming word is about to become the oldest.
      if (pop_ok) begin
        if (count_reg > ONE_COUNT) begin
          head_reg <= mem[rd_ptr_next];
        end else if (push_ok) begin
          head_reg <= push_data;
        end
      end else if (push_ok && empty) begin
        head_reg <= push_data;
      end
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// Replays buffered host commands as the controller's operation word: compute
// passes followed by a drain gap, and write bursts paced by a data handshake.
module op_sequencer #(
  parameter int DEPTH        = 4,
  parameter int PASS_CYCLES  = 64,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data_in,
  output logic [31:0] operation,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  import dnn_seq_pkg::*;

  localparam int CNT_MAX = (PASS_CYCLES > DRAIN_CYCLES) ? PASS_CYCLES : DRAIN_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PASS_LAST  = CW'(PASS_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  seq_state_t        state_reg;
  logic [PASS_MSB:0] cur_reg;
  logic [CW-1:0]     cnt_reg;
  logic [7:0]        beats_reg;
  logic              done_reg;
  logic              err_reg;

  logic [31:0] fifo_head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_push;
  logic        fifo_pop;
  logic        beat;
  logic        op_active;

  assign cmd_ready  = ~fifo_full & enable & ~reset;
  assign fifo_push  = cmd_valid & cmd_ready;
  assign fifo_pop   = enable & (state_reg == ST_IDLE) & ~fifo_empty;
  assign beat       = enable & data_valid & (state_reg == ST_WRITE);
  assign op_active  = (state_reg == ST_COMPUTE) | beat;
  assign data_ready = enable & ~reset & (state_reg == ST_WRITE);
  assign out_data   = (state_reg == ST_WRITE) ? data_in : 32'd0;
  assign busy       = ~reset & ((state_reg != ST_IDLE) | ~fifo_empty);
  assign done       = done_reg;
  assign err        = err_reg;

  // Length bits never reach the controller.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_op
      if (gi <= PASS_MSB) begin : g_pass
        assign operation[gi] = cur_reg[gi] & op_active;
      end else begin : g_zero
        assign operation[gi] = 1'b0;
      end
    end
  endgenerate

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (cmd_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cur_reg   <= '0;
      cnt_reg   <= '0;
      beats_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      // done is a pulse, so it drops even while the sequencer is frozen.
      done_reg <= 1'b0;
      if (enable) begin
        case (state_reg)
          ST_IDLE: begin
            if (!fifo_empty) begin
              case (fifo_head[3:0])
                MODE_COMPUTE: begin
                  state_reg <= ST_COMPUTE;
                  cnt_reg   <= '0;
                  cur_reg   <= fifo_head[PASS_MSB:0];
                end
                MODE_WRITE: begin
                  state_reg <= ST_WRITE;
                  beats_reg <= fifo_head[31:LEN_LSB];
                  cur_reg   <= fifo_head[PASS_MSB:0];
                end
                MODE_NOP: begin
                  state_reg <= ST_IDLE;
                end
                default: begin
                  err_reg <= 1'b1;
                end
              endcase
            end
          end
          ST_COMPUTE: begin
            if (cnt_reg == PASS_LAST) begin
              state_reg <= ST_DRAIN;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_DRAIN: begin
            // The drain gap plus the IDLE pop cycle guarantees a fresh mode-1 edge.
            if (cnt_reg == DRAIN_LAST) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
              done_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_WRITE: begin
            if (data_valid) begin
              if (beats_reg == 8'd0) begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
              end else begin
                beats_reg <= beats_reg - 1'b1;
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed timing scenarios plus a randomized command
// stream checked against a transaction-level expectation queue.
module tb_op_sequencer;

  localparam int DEPTH = 4;
  localparam int PASS  = 64;
  localparam int DRAIN = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_word;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_in;
  logic [31:0] operation;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  op_sequencer #(
    .DEPTH        (DEPTH),
    .PASS_CYCLES  (PASS),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_word   (cmd_word),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_in    (data_in),
    .operation  (operation),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    next_cycle();
    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0;
    cmd_word = 32'h0; data_in = 32'hdead_beef;
    next_cycle();
    sample();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready_in_reset: got %b expected 0", cmd_ready); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_data_ready_in_reset: got %b expected 0", data_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_in_reset: got %b expected 0", busy); end
    next_cycle();
    reset = 1'b0;
    sample();
    total++; if (operation !== 32'h0) begin bad++; $display("FAIL rst_operation: got %h expected 0", operation); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b expected 0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_data_ready: got %b expected 0", data_ready); end
    $display("reset checked");
  endtask

  task automatic test_compute();
    int hold_bad  = 0;
    int drain_bad = 0;
    next_cycle(); cmd_valid = 1'b1; cmd_word = 32'h0003_0121;
    sample();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmp_accept: got %b expected 1", cmd_ready); end
    next_cycle(); cmd_valid = 1'b0;
    sample();
    total++; if (operation !== 32'h0) begin bad++; $display("FAIL cmp_t1_operation: got %h expected 0", operation); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cmp_t1_busy: got %b expected 1", busy); end
    for (int k = 2; k <= 65; k++) begin
      next_cycle(); sample();
      if (operation !== 32'h0003_0121) hold_bad++;
    end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL cmp_hold: got %0d wrong cycles expected 0", hold_bad); end
    for (int k = 66; k <= 81; k++) begin
      next_cycle(); sample();
      if (operation !== 32'h0 || done !== 1'b0) drain_bad++;
    end
    total++; if (drain_bad != 0) begin bad++; $display("FAIL cmp_drain: got %0d wrong cycles expected 0", drain_bad); end
    next_cycle(); sample();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL cmp_done_t82: got %b expected 1", done); end
    total++; if (operation !== 32'h0) begin bad++; $display("FAIL cmp_t82_operation: got %h expected 0", operation); end
    next_cycle(); sample();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cmp_done_pulse: got %b expected 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cmp_idle_busy: got %b expected 0", busy); end
    $display("compute cmd=00030121 checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1 = 32'h0000_0011;
    logic [31:0] w2 = 32'h0055_0231;
    int c1 = 0, c2 = 0, gap = 0, dones = 0, order_bad = 0, phase = 0, cyc = 0;
    next_cycle(); cmd_valid = 1'b1; cmd_word = w1;
    sample();
    while (dones < 2 && cyc < 400) begin
      next_cycle();
      cmd_valid = (cyc == 0);
      cmd_word  = w2;
      sample();
      if (done === 1'b1) dones++;
      if (operation === w1) begin
        c1++;
        if (phase == 0) phase = 1;
        if (phase > 1) order_bad++;
      end else if (operation === w2) begin
        c2++;
        if (phase == 2) phase = 3;
        if (phase < 2 || phase > 3) order_bad++;
      end else if (operation === 32'h0) begin
        if (phase == 1) phase = 2;
        if (phase == 2) gap++;
        if (phase == 3) phase = 4;
      end else begin
        order_bad++;
      end
      cyc++;
    end
    cmd_valid = 1'b0;
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_dones: got %0d expected 2", dones); end
    total++; if (c1 != PASS) begin bad++; $display("FAIL b2b_pass1_len: got %0d expected %0d", c1, PASS); end
    total++; if (c2 != PASS) begin bad++; $display("FAIL b2b_pass2_len: got %0d expected %0d", c2, PASS); end
    total++; if (gap != DRAIN + 1) begin bad++; $display("FAIL b2b_gap: got %0d expected %0d", gap, DRAIN + 1); end
    total++; if (order_bad != 0) begin bad++; $display("FAIL b2b_order: got %0d stray cycles expected 0", order_bad); end
    $display("back-to-back cmds=%h,%h checked", w1, w2);
  endtask

  task automatic test_write();
    int pat [6] = '{1, 0, 1, 1, 0, 1};
    logic [31:0] exp_op;
    next_cycle(); cmd_valid = 1'b1; cmd_word = 32'h0300_0082; data_valid = 1'b0;
    sample();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_accept: got %b expected 1", cmd_ready); end
    next_cycle(); cmd_valid = 1'b0;
    sample();
    total++; if (operation !== 32'h0) begin bad++; $display("FAIL wr_t1_operation: got %h expected 0", operation); end
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      data_valid = pat[j][0];
      data_in    = $urandom;
      sample();
      exp_op = (pat[j] != 0) ? 32'h0000_0082 : 32'h0;
      total++; if (operation !== exp_op) begin bad++; $display("FAIL wr_operation[%0d]: got %h expected %h", j, operation, exp_op); end
      total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL wr_data_ready[%0d]: got %b expected 1", j, data_ready); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL wr_early_done[%0d]: got %b expected 0", j, done); end
      if (pat[j] != 0) begin
        total++; if (out_data !== data_in) begin bad++; $display("FAIL wr_out_data[%0d]: got %h expected %h", j, out_data, data_in); end
        $display("write beat data=%h", data_in);
      end
    end
    next_cycle(); data_valid = 1'b0;
    sample();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL wr_done: got %b expected 1", done); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL wr_end_data_ready: got %b expected 0", data_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL wr_end_out_data: got %h expected 0", out_data); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] p [5];
    int blocked = 0, dones = 0, err_early = 0, sticky_bad = 0, cyc = 0, late_done = 0;
    bit err_seen = 1'b0;
    p = '{32'h0000_0000, 32'h0000_0017, 32'h0012_3451, 32'h0ff0_0000, 32'h0000_0061};
    data_valid = 1'b0;
    next_cycle(); cmd_valid = 1'b1; cmd_word = 32'h0000_0001;
    sample();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_first_accept: got %b expected 1", cmd_ready); end
    for (int k = 0; k < 4; k++) begin
      next_cycle(); cmd_word = p[k];
      sample();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_fill[%0d]: got %b expected 1", k, cmd_ready); end
      $display("push cmd=%h", p[k]);
    end
    next_cycle(); cmd_word = p[4];
    sample();
    while (cmd_ready !== 1'b1 && blocked < 200) begin
      blocked++;
      if (done === 1'b1) dones++;
      if (err !== 1'b0) err_early++;
      next_cycle(); sample();
    end
    if (done === 1'b1) dones++;
    // Cycles T+5 .. T+82 are blocked: the pop at T+82 does not free a slot for that cycle.
    total++; if (blocked != 78) begin bad++; $display("FAIL full_blocked_cycles: got %0d expected 78", blocked); end
    total++; if (err_early != 0) begin bad++; $display("FAIL full_err_early: got %0d expected 0", err_early); end
    $display("push cmd=%h", p[4]);
    while (!(dones == 3 && busy === 1'b0) && cyc < 400) begin
      next_cycle(); cmd_valid = 1'b0;
      sample();
      if (done === 1'b1) dones++;
      if (err === 1'b1) err_seen = 1'b1;
      else if (err_seen) sticky_bad++;
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      next_cycle(); sample();
      if (done === 1'b1) late_done++;
    end
    total++; if (dones != 3) begin bad++; $display("FAIL full_dones: got %0d expected 3", dones); end
    total++; if (late_done != 0) begin bad++; $display("FAIL full_nop_done: got %0d expected 0", late_done); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL full_err_set: got %b expected 1", err); end
    total++; if (sticky_bad != 0) begin bad++; $display("FAIL full_err_sticky: got %0d drops expected 0", sticky_bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w  = 32'h0000_0a71;
    logic [31:0] w3 = 32'h0000_0d21;
    int after_bad = 0, run = 0, stray = 0, cyc = 0;
    next_cycle(); cmd_valid = 1'b1; cmd_word = w;
    sample();
    next_cycle(); cmd_word = 32'h0000_0b81;
    sample();
    for (int k = 2; k <= 31; k++) begin
      next_cycle(); cmd_valid = 1'b0;
      sample();
    end
    total++; if (operation !== w) begin bad++; $display("FAIL rmid_running: got %h expected %h", operation, w); end
    next_cycle(); reset = 1'b1;
    sample();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rmid_cmd_ready: got %b expected 0", cmd_ready); end
    next_cycle(); reset = 1'b0;
    sample();
    total++; if (operation !== 32'h0) begin bad++; $display("FAIL rmid_operation: got %h expected 0", operation); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err: got %b expected 0", err); end
    for (int k = 0; k < 5; k++) begin
      next_cycle(); sample();
      if (operation !== 32'h0 || busy !== 1'b0) after_bad++;
    end
    total++; if (after_bad != 0) begin bad++; $display("FAIL rmid_no_replay: got %0d active cycles expected 0", after_bad); end
    next_cycle(); cmd_valid = 1'b1; cmd_word = w3;
    sample();
    while (done !== 1'b1 && cyc < 300) begin
      next_cycle(); cmd_valid = 1'b0;
      sample();
      if (operation === w3) run++;
      else if (operation !== 32'h0) stray++;
      cyc++;
    end
    total++; if (run != PASS) begin bad++; $display("FAIL rmid_new_pass: got %0d expected %0d", run, PASS); end
    total++; if (stray != 0) begin bad++; $display("FAIL rmid_stray_op: got %0d expected 0", stray); end
    $display("reset mid-pass then cmd=%h checked", w3);
  endtask

  task automatic test_enable();
    logic [31:0] w = 32'h0000_0c11;
    int en_cnt = 0, dis_cnt = 0, hold_bad = 0, done_at = -1;
    next_cycle(); cmd_valid = 1'b1; cmd_word = w;
    sample();
    next_cycle(); cmd_valid = 1'b0;
    sample();
    for (int i = 2; i < 300 && done_at < 0; i++) begin
      next_cycle();
      enable = !(i >= 22 && i < 32);
      sample();
      if (operation === w) begin
        if (enable) en_cnt++;
        else dis_cnt++;
      end
      if (!enable && (cmd_ready !== 1'b0 || data_ready !== 1'b0 || operation !== w)) hold_bad++;
      if (done === 1'b1) done_at = i;
    end
    enable = 1'b1;
    total++; if (en_cnt != PASS) begin bad++; $display("FAIL en_pass_len: got %0d expected %0d", en_cnt, PASS); end
    total++; if (dis_cnt != 10) begin bad++; $display("FAIL en_held_cycles: got %0d expected 10", dis_cnt); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL en_frozen: got %0d bad cycles expected 0", hold_bad); end
    total++; if (done_at != 2 + PASS + 10 + DRAIN) begin bad++; $display("FAIL en_done_cycle: got %0d expected %0d", done_at, 2 + PASS + 10 + DRAIN); end
    $display("enable-gap cmd=%h checked", w);
  endtask

  task automatic test_random();
    logic [31:0] cmds [$];
    logic [31:0] exp_word [$];
    int          exp_cnt [$];
    bit          exp_comp [$];
    int  n_done_exp = 0, dones = 0, item = 0, rem = 0, zeros = 0, pushed = 0, cyc = 0;
    int  seq_bad = 0, gap_bad = 0, data_bad = 0, mid_bad = 0, gate_bad = 0;
    bit  exp_err = 1'b0, prev_comp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int          r;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      w = $urandom;
      if (r <= 3) begin
        w[3:0] = 4'd1;
        exp_word.push_back(w & 32'h00ff_ffff); exp_cnt.push_back(PASS); exp_comp.push_back(1'b1);
        n_done_exp++;
      end else if (r <= 6) begin
        w[3:0]   = 4'd2;
        w[31:24] = 8'($urandom_range(0, 3));
        exp_word.push_back(w & 32'h00ff_ffff); exp_cnt.push_back(int'(w[31:24]) + 1); exp_comp.push_back(1'b0);
        n_done_exp++;
      end else if (r == 7) begin
        w[3:0] = 4'd0;
      end else begin
        w[3:0]  = 4'($urandom_range(3, 15));
        exp_err = 1'b1;
      end
      cmds.push_back(w);
    end
    rem = (exp_word.size() > 0) ? exp_cnt[0] : 0;
    while (cyc < 4000) begin
      next_cycle();
      enable     = ($urandom_range(0, 9) != 0);
      cmd_valid  = (pushed < cmds.size()) && ($urandom_range(0, 1) == 1);
      cmd_word   = (pushed < cmds.size()) ? cmds[pushed] : $urandom;
      data_valid = $urandom_range(0, 1);
      data_in    = $urandom;
      sample();
      if (cmd_valid && cmd_ready === 1'b1) begin
        $display("push cmd=%h", cmds[pushed]);
        pushed++;
      end
      if (done === 1'b1) dones++;
      if (!enable && (cmd_ready !== 1'b0 || data_ready !== 1'b0)) gate_bad++;
      if (enable) begin
        if (operation !== 32'h0) begin
          if (item >= exp_word.size() || operation !== exp_word[item]) begin
            seq_bad++;
          end else begin
            if (rem == exp_cnt[item] && prev_comp && zeros < DRAIN + 1) gap_bad++;
            if (!exp_comp[item] && out_data !== data_in) data_bad++;
            rem--;
            if (rem == 0) begin
              $display("complete op=%h beats=%0d", exp_word[item], exp_cnt[item]);
              prev_comp = exp_comp[item];
              item++;
              rem = (item < exp_word.size()) ? exp_cnt[item] : 0;
            end
          end
          zeros = 0;
        end else begin
          zeros++;
          if (item < exp_word.size() && exp_comp[item] && rem != exp_cnt[item]) mid_bad++;
        end
      end
      cyc++;
      if (pushed == cmds.size() && item == exp_word.size() && busy === 1'b0 && dones == n_done_exp) break;
    end
    enable = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0;
    total++; if (item != exp_word.size()) begin bad++; $display("FAIL rnd_items: got %0d expected %0d", item, exp_word.size()); end
    total++; if (seq_bad != 0) begin bad++; $display("FAIL rnd_sequence: got %0d wrong words expected 0", seq_bad); end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL rnd_drain_gap: got %0d short gaps expected 0", gap_bad); end
    total++; if (mid_bad != 0) begin bad++; $display("FAIL rnd_pass_break: got %0d expected 0", mid_bad); end
    total++; if (data_bad != 0) begin bad++; $display("FAIL rnd_out_data: got %0d expected 0", data_bad); end
    total++; if (gate_bad != 0) begin bad++; $display("FAIL rnd_enable_gate: got %0d expected 0", gate_bad); end
    total++; if (dones != n_done_exp) begin bad++; $display("FAIL rnd_dones: got %0d expected %0d", dones, n_done_exp); end
    total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err: got %b expected %b", err, exp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_drained: got %b expected 0", busy); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0;
    cmd_word = 32'h0; data_in = 32'h0;
    test_reset();
    test_compute();
    test_back_to_back();
    test_write();
    test_fifo_full();
    test_reset_mid();
    test_enable();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
